// File: rtl/axi_ch_rr_arb_pkg.sv
// Shared definitions for the round-robin channel arbiter: state encoding, defaults and helpers.
package axi_ch_rr_arb_pkg;

    localparam int unsigned P_WIDTH_DEF = 77;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_ch_rr_arb_retime.sv
// Single-entry channel retime register; only the low P_RSTW payload bits are reset.
module axi_ch_rr_arb_retime #(
    parameter int unsigned P_W    = 8,
    parameter int unsigned P_RSTW = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [P_W-1:0] i_data,
    input  logic           i_val,
    output logic           o_rdy_up,
    output logic [P_W-1:0] o_data,
    output logic           o_val,
    input  logic           i_rdy_dn
);

    logic           r_val;
    logic [P_W-1:0] r_data;
    logic           w_load;

    assign o_rdy_up = ~r_val | i_rdy_dn;
    assign w_load   = o_rdy_up & i_val;
    assign o_val    = r_val;
    assign o_data   = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_val               <= 1'b0;
            r_data[P_RSTW-1:0]  <= '0;
        end else begin
            if (o_rdy_up) begin
                r_val <= i_val;
            end
            if (w_load) begin
                r_data[P_RSTW-1:0] <= i_data[P_RSTW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_data[P_W-1:P_RSTW] <= i_data[P_W-1:P_RSTW];
        end
    end

endmodule

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: lowest set request strictly after i_ptr, wrapping around.
module axi_rr_pick #(
    parameter int unsigned P_N   = 4,
    parameter int unsigned P_IDW = 2
) (
    input  logic [P_N-1:0]   i_req,
    input  logic [P_IDW-1:0] i_ptr,
    output logic [P_N-1:0]   o_gnt,
    output logic [P_IDW-1:0] o_idx,
    output logic             o_any
);

    logic [2*P_N-1:0] w_dbl;

    // Lower half holds only requests above the pointer, upper half all of them,
    // so the lowest set bit of the doubled vector is the round-robin winner.
    always_comb begin
        w_dbl = '0;
        for (int i = 0; i < int'(P_N); i++) begin
            w_dbl[i]       = i_req[i] && (i > int'(i_ptr));
            w_dbl[i + P_N] = i_req[i];
        end
        o_idx = '0;
        for (int i = 2 * int'(P_N) - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                o_idx = P_IDW'(i % int'(P_N));
            end
        end
        o_any = |i_req;
        o_gnt = '0;
        for (int i = 0; i < int'(P_N); i++) begin
            o_gnt[i] = o_any && (o_idx == P_IDW'(i));
        end
    end

endmodule

// File: rtl/axi_ch_rr_arb.sv
// Round-robin arbiter sharing one valid/ready channel among P_N requesters,
// with optional packet locking and a registered output carrying the winner index.
module axi_ch_rr_arb
    import axi_ch_rr_arb_pkg::*;
#(
    parameter int unsigned P_WIDTH = P_WIDTH_DEF,
    parameter int unsigned P_N     = 4,
    parameter int unsigned P_IDW   = 2,
    parameter bit          P_LOCK  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [P_N*P_WIDTH-1:0] i_data,
    input  logic [P_N-1:0]       i_val,
    input  logic [P_N-1:0]       i_last,
    output logic [P_N-1:0]       i_rdy,
    output logic [P_WIDTH-1:0]   o_data,
    output logic [P_IDW-1:0]     o_id,
    output logic                 o_last,
    output logic                 o_val,
    input  logic                 o_rdy
);

    localparam int unsigned L_OW = P_WIDTH + P_IDW + 1;

    arb_state_e       r_state;
    logic [P_IDW-1:0] r_ptr;
    logic [P_IDW-1:0] r_gnt;

    logic [P_N-1:0]     w_pick_gnt;
    logic [P_IDW-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_stage_rdy;
    logic               w_has_sel;
    logic [P_IDW-1:0]   w_sel;
    logic               w_xfer;
    logic [P_WIDTH-1:0] w_sel_data;
    logic               w_sel_last;
    logic [L_OW-1:0]    w_out;

    axi_rr_pick #(
        .P_N   (P_N),
        .P_IDW (P_IDW)
    ) u_pick (
        .i_req (i_val),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // While locked the owner keeps its ready even if its valid drops mid-packet.
    always_comb begin
        w_sel     = (r_state == LOCKED) ? r_gnt : w_pick_idx;
        w_has_sel = (r_state == LOCKED) | w_pick_any;
        i_rdy     = '0;
        for (int k = 0; k < int'(P_N); k++) begin
            i_rdy[k] = w_stage_rdy && w_has_sel && (w_sel == P_IDW'(k));
        end
        w_xfer     = |(i_val & i_rdy);
        w_sel_data = i_data[int'(w_sel)*P_WIDTH +: P_WIDTH];
        w_sel_last = i_last[w_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= P_IDW'(P_N - 1);
            r_gnt   <= '0;
        end else if (w_xfer) begin
            case (r_state)
                IDLE: begin
                    r_ptr <= w_sel;
                    r_gnt <= w_sel;
                    if (P_LOCK && !w_sel_last) begin
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_sel_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    axi_ch_rr_arb_retime #(
        .P_W    (L_OW),
        .P_RSTW (P_IDW + 1)
    ) u_retime (
        .clk      (clk),
        .reset    (reset),
        .i_data   ({w_sel_data, w_sel, w_sel_last}),
        .i_val    (w_xfer),
        .o_rdy_up (w_stage_rdy),
        .o_data   (w_out),
        .o_val    (o_val),
        .i_rdy_dn (o_rdy)
    );

    assign o_data = w_out[L_OW-1 -: P_WIDTH];
    assign o_id   = w_out[P_IDW:1];
    assign o_last = w_out[0];

endmodule
